// File: rtl/conv_result_collector_pkg.sv
// Shared sizing helpers and FSM encoding for the convolution result collector.
// Result words are 2*dataSize+5 bits wide; a frame holds (IMG_WIDTH-1)^2 windows.
package conv_result_collector_pkg;

  function automatic int unsigned calc_res_w(input int unsigned data_size);
    return 2 * data_size + 5;
  endfunction

  function automatic int unsigned calc_nwin(input int unsigned img_width);
    return (img_width - 1) * (img_width - 1);
  endfunction

  typedef enum logic [1:0] {
    StIdle,
    StCollect,
    StDrain,
    StDone
  } state_e;

endpackage

// File: rtl/conv_result_collector_sync_fifo.sv
// Registered FIFO with wrap-bit pointers and a synchronous flush.
// When empty, rd_data shows the most recently popped word.
module conv_result_collector_sync_fifo #(
  parameter int unsigned WIDTH = 22,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] hold_q;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is still taken.
  assign do_push = push && (!full || do_pop);
  assign rd_data = empty ? hold_q : mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      hold_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (do_pop) hold_q <= mem_q[rd_ptr_q[AW-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/conv_result_collector.sv
// Collects convolution window results for one frame, applies optional ReLU,
// buffers them and streams them out over valid/ready with a last tag and done pulse.
module conv_result_collector
  import conv_result_collector_pkg::*;
#(
  parameter int unsigned dataSize   = 8,
  parameter int unsigned IMG_WIDTH  = 3,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter bit          RELU_EN    = 1'b1,
  localparam int unsigned RES_W     = calc_res_w(dataSize),
  localparam int unsigned NWIN      = calc_nwin(IMG_WIDTH),
  localparam int unsigned CNT_W     = $clog2(NWIN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_start,
  input  logic             win_valid,
  input  logic [RES_W-1:0] win_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [RES_W-1:0] out_data,
  output logic             out_last,
  output logic [CNT_W-1:0] win_count,
  output logic             overflow,
  output logic             frame_done
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             overflow_q, overflow_d;

  logic             push_req;
  logic             is_last;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [RES_W-1:0] relu_data;
  logic [RES_W:0]   fifo_rd_data;

  // frame_start wins over a coincident window: the new frame starts clean.
  assign push_req  = (state_q == StCollect) && win_valid && !frame_start;
  assign is_last   = (cnt_q == CNT_W'(NWIN - 1));
  assign relu_data = (RELU_EN && win_result[RES_W-1]) ? '0 : win_result;

  assign out_valid  = !fifo_empty;
  assign pop        = out_valid && out_ready;
  assign out_data   = fifo_rd_data[RES_W-1:0];
  assign out_last   = out_valid && fifo_rd_data[RES_W];
  assign win_count  = cnt_q;
  assign overflow   = overflow_q;
  assign frame_done = (state_q == StDone);

  conv_result_collector_sync_fifo #(
    .WIDTH(RES_W + 1),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .flush  (frame_start),
    .push   (push_req),
    .pop    (pop),
    .wr_data({is_last, relu_data}),
    .rd_data(fifo_rd_data),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  always_comb begin
    state_d = state_q;
    if (frame_start) begin
      state_d = StCollect;
    end else begin
      unique case (state_q)
        StIdle:    state_d = StIdle;
        StCollect: if (push_req && is_last) state_d = StDrain;
        // An empty FIFO here means the tagged word was dropped on overflow.
        StDrain:   if ((pop && out_last) || fifo_empty) state_d = StDone;
        StDone:    state_d = StIdle;
        default:   state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    cnt_d      = cnt_q;
    overflow_d = overflow_q;
    if (frame_start) begin
      cnt_d = '0;
    end else if (push_req) begin
      // Dropped words still count so the last tag stays tied to image position.
      cnt_d = cnt_q + 1'b1;
      if (fifo_full && !pop) overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      overflow_q <= overflow_d;
    end
  end

endmodule
